// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_tracker
// Purpose  : PS/2 scan-code tracker. Decodes make, break and E0-extended
//            sequences from a byte stream. It tracks the currently held key,
//            counts new presses with saturation, and keeps a circular history
//            of the most recent HIST_DEPTH pressed keys. The history can be
//            read back by index.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   HIST_DEPTH    history entries (power of 2, >= 2)
//   CNT_W         press counter width
// Ports
//   clk           system clock, all logic on posedge
//   rst           synchronous active-low reset
//   ps2_data      received scan-code byte, qualified by ps2_valid
//   ps2_valid     one-cycle strobe per received byte
//   hist_rd_idx   history read index, 0 = most recent entry
//   key_code      scan code of the held key (0 when none is held)
//   key_ext       held key was E0-prefixed
//   key_down      a key is currently held
//   press_cnt     saturating count of new presses
//   hist_cnt      valid history entries, saturating at HIST_DEPTH
//   hist_rd_data  {ext, code} at hist_rd_idx, 0 beyond hist_cnt (1-cycle latency)
//   ovf           sticky: a history push overwrote the oldest entry
// Build option
//   KBD_TYPEMATIC_COUNT_EN  when defined, a typematic repeat of the held key
//                           counts as a press and is pushed into the history.
//                           When undefined, typematic repeats are ignored.
// ============================================================================
module ps2_key_tracker #(
  parameter int HIST_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      ps2_data,
  input  logic                            ps2_valid,
  input  logic [$clog2(HIST_DEPTH)-1:0]   hist_rd_idx,
  output logic [7:0]                      key_code,
  output logic                            key_ext,
  output logic                            key_down,
  output logic [CNT_W-1:0]                press_cnt,
  output logic [$clog2(HIST_DEPTH+1)-1:0] hist_cnt,
  output logic [8:0]                      hist_rd_data,
  output logic                            ovf
);

  localparam int c_ptr_w = $clog2(HIST_DEPTH);
  localparam int c_hc_w  = $clog2(HIST_DEPTH+1);

  localparam logic [7:0]        c_byte_ext  = 8'hE0;
  localparam logic [7:0]        c_byte_brk  = 8'hF0;
  localparam logic [c_hc_w-1:0] c_hist_full = c_hc_w'(HIST_DEPTH);
  localparam logic [CNT_W-1:0]  c_cnt_max   = '1;

`ifdef KBD_TYPEMATIC_COUNT_EN
  localparam logic c_typematic_en = 1'b1;
`else
  localparam logic c_typematic_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_EXT  = 2'd1,
    ST_BRK  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_ext_pend;
  logic                w_ext_pend_nxt;

  logic                w_make;
  logic                w_make_ext;
  logic                w_release;
  logic                w_repeat;
  logic                w_load;
  logic                w_push;

  logic [8:0]          r_hist [HIST_DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  w_rd_slot;
  logic                w_rd_valid;

  // --------------------------------------------------------------------------
  // Sequence FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_WAIT;
      r_ext_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ext_pend <= w_ext_pend_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Sequence FSM: next state and byte classification
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_ext_pend_nxt = r_ext_pend;
    w_make         = 1'b0;
    w_make_ext     = 1'b0;
    w_release      = 1'b0;

    if (ps2_valid) begin
      case (r_state)
        ST_WAIT: begin
          if (ps2_data == c_byte_ext) begin
            w_state_nxt    = ST_EXT;
            w_ext_pend_nxt = 1'b1;
          end else if (ps2_data == c_byte_brk) begin
            w_state_nxt = ST_BRK;
          end else begin
            w_make     = 1'b1;
            w_make_ext = 1'b0;
          end
        end

        ST_EXT: begin
          if (ps2_data == c_byte_brk) begin
            w_state_nxt = ST_BRK;
          end else if (ps2_data == c_byte_ext) begin
            w_state_nxt = ST_EXT;
          end else begin
            // The prefix is consumed by this make. Clearing it here stops a
            // later plain F0 from being treated as an extended break.
            w_make         = 1'b1;
            w_make_ext     = 1'b1;
            w_state_nxt    = ST_WAIT;
            w_ext_pend_nxt = 1'b0;
          end
        end

        ST_BRK: begin
          // A break releases the key only if both the prefix and the code
          // match the held key. Any other break byte is dropped.
          w_release      = key_down &&
                           ({r_ext_pend, ps2_data} == {key_ext, key_code});
          w_state_nxt    = ST_WAIT;
          w_ext_pend_nxt = 1'b0;
        end

        default: begin
          w_state_nxt    = ST_WAIT;
          w_ext_pend_nxt = 1'b0;
        end
      endcase
    end
  end

  // A make that matches the held key is an auto-repeat from the keyboard.
  assign w_repeat = key_down && ({w_make_ext, ps2_data} == {key_ext, key_code});
  assign w_load   = w_make && !w_repeat;
  assign w_push   = w_make && (!w_repeat || c_typematic_en);

  // Entry k (0 = newest) lives k+1 slots behind the write pointer. The
  // subtraction wraps modulo HIST_DEPTH because the depth is a power of 2.
  assign w_rd_slot  = r_wr_ptr - c_ptr_w'(1) - hist_rd_idx;
  assign w_rd_valid = c_hc_w'(hist_rd_idx) < hist_cnt;

  // --------------------------------------------------------------------------
  // Held key, press counter, history buffer and read port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_code     <= 8'h00;
      key_ext      <= 1'b0;
      key_down     <= 1'b0;
      press_cnt    <= '0;
      hist_cnt     <= '0;
      ovf          <= 1'b0;
      r_wr_ptr     <= '0;
      hist_rd_data <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        r_hist[i] <= '0;
      end
    end else begin
      if (w_release) begin
        key_code <= 8'h00;
        key_ext  <= 1'b0;
        key_down <= 1'b0;
      end else if (w_load) begin
        key_code <= ps2_data;
        key_ext  <= w_make_ext;
        key_down <= 1'b1;
      end

      if (w_push) begin
        if (press_cnt != c_cnt_max) begin
          press_cnt <= press_cnt + CNT_W'(1);
        end
        r_hist[r_wr_ptr] <= {w_make_ext, ps2_data};
        r_wr_ptr         <= r_wr_ptr + c_ptr_w'(1);
        if (hist_cnt == c_hist_full) begin
          ovf <= 1'b1;
        end else begin
          hist_cnt <= hist_cnt + c_hc_w'(1);
        end
      end

      // This read uses the pointer and contents from before any push in the
      // same cycle.
      hist_rd_data <= w_rd_valid ? r_hist[w_rd_slot] : 9'h000;
    end
  end

endmodule
`default_nettype wire
